// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC core: opcodes, bubble encoding
// and the instruction-fetch state machine encoding.
package wisc_pkg;

    localparam logic [3:0]  OP_HLT   = 4'hF;
    localparam logic [3:0]  OP_B     = 4'hC;
    localparam logic [3:0]  OP_BR    = 4'hD;
    localparam logic [15:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic isOpcode(input logic [15:0] inst, input logic [3:0] op);
        return inst[15:12] == op;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; a bubble request overrides hold, otherwise the
// register loads a valid instruction every cycle it is not held.
module if_id_reg
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  logic [15:0] inst,
    input  logic [15:0] pc_plus2,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            if_id_inst     <= NOP_INST;
            if_id_pc_plus2 <= 16'h0000;
            if_id_valid    <= 1'b0;
        end else if (!hold) begin
            if_id_inst     <= inst;
            if_id_pc_plus2 <= pc_plus2;
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, redirect bookkeeping across memory misses,
// HLT handling, and the IF/ID register that feeds decode.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = OP_HLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_flush,
    input  logic [15:0] br_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic         r_redirPend;
    logic [15:0]  r_redirPc;

    fetch_state_t w_nextState;
    logic [15:0]  w_nextPc;
    logic         w_nextPend;
    logic [15:0]  w_nextRedirPc;
    logic [15:0]  w_pcPlus2;
    logic         w_isHalt;
    logic         w_bubble;
    logic         w_hold;

    assign imem_req  = (r_state != HALT);
    assign imem_addr = r_pc;
    assign w_pcPlus2 = r_pc + 16'd2;
    assign w_isHalt  = isOpcode(imem_data, HALT_OPCODE);

    always_comb begin
        w_nextState   = r_state;
        w_nextPc      = r_pc;
        w_nextPend    = r_redirPend;
        w_nextRedirPc = r_redirPc;
        w_bubble      = 1'b0;
        w_hold        = 1'b0;
        if (if_flush) begin
            w_bubble = 1'b1;
            // A miss still in flight must finish before the redirect can be applied.
            if (r_state == MISS && !imem_valid) begin
                w_nextPend    = 1'b1;
                w_nextRedirPc = br_target;
            end else begin
                w_nextPc    = br_target;
                w_nextPend  = 1'b0;
                w_nextState = RUN;
            end
        end else begin
            unique case (r_state)
                RUN, MISS: begin
                    if (imem_valid && r_state == MISS && r_redirPend) begin
                        w_nextPc    = r_redirPc;
                        w_nextPend  = 1'b0;
                        w_nextState = RUN;
                        w_hold      = stall;
                        w_bubble    = !stall;
                    end else if (imem_valid) begin
                        w_nextState = RUN;
                        if (stall) begin
                            w_hold = 1'b1;
                        end else if (w_isHalt) begin
                            w_nextState = HALT;
                        end else begin
                            w_nextPc = w_pcPlus2;
                        end
                    end else begin
                        w_nextState = MISS;
                        w_hold      = stall;
                        w_bubble    = !stall;
                    end
                end
                HALT: begin
                    w_hold   = stall;
                    w_bubble = !stall;
                end
                default: begin
                    w_nextState = RUN;
                    w_bubble    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_pc        <= PC_RESET;
            r_redirPend <= 1'b0;
            r_redirPc   <= 16'h0000;
            halted      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pc        <= w_nextPc;
            r_redirPend <= w_nextPend;
            r_redirPc   <= w_nextRedirPc;
            halted      <= (w_nextState == HALT);
        end
    end

    if_id_reg u_ifIdReg (
        .clk            (clk),
        .rst            (rst),
        .hold           (w_hold),
        .bubble         (w_bubble),
        .inst           (imem_data),
        .pc_plus2       (w_pcPlus2),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID entries,
// a negedge monitor pops and compares whenever IF/ID reports a valid word.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        ifFlush;
    logic [15:0] brTarget;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemValid;
    logic [15:0] ifIdInst;
    logic [15:0] ifIdPcPlus2;
    logic        ifIdValid;
    logic        halted;

    logic [15:0] hltAddr = 16'hFFFF;
    logic [31:0] expQ[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    // Memory model: HLT at the chosen address, otherwise opcode 1 tagged with the address.
    function automatic logic [15:0] memWord(input logic [15:0] addr, input logic [15:0] hAddr);
        logic [15:0] w;
        w = {4'h1, addr[11:0]};
        if (addr == hAddr) w = 16'hF000;
        return w;
    endfunction

    assign imemData = memWord(imemAddr, hltAddr);

    fetch_stage dut (
        .clk            (clock),
        .rst            (reset),
        .stall          (stall),
        .if_flush       (ifFlush),
        .br_target      (brTarget),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_data      (imemData),
        .imem_valid     (imemValid),
        .if_id_inst     (ifIdInst),
        .if_id_pc_plus2 (ifIdPcPlus2),
        .if_id_valid    (ifIdValid),
        .halted         (halted)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic [15:0] tgt, input logic vld);
        stall     = st;
        ifFlush   = fl;
        brTarget  = tgt;
        imemValid = vld;
        @(posedge clock);
        #1;
    endtask

    task automatic expectFetch(input logic [15:0] inst, input logic [15:0] pcPlus2);
        expQ.push_back({inst, pcPlus2});
    endtask

    // Monitor: each valid IF/ID cycle must match the next scoreboard entry.
    always @(negedge clock) begin
        if (!reset && ifIdValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ifid", {ifIdInst, ifIdPcPlus2}, 32'h0);
            end else begin
                checkOutput("ifid_entry", {ifIdInst, ifIdPcPlus2}, expQ.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        checkOutput("reset_addr",   {16'h0, imemAddr}, 32'h0000_0000);
        checkOutput("reset_req",    {31'h0, imemReq}, 32'h1);
        checkOutput("reset_halted", {31'h0, halted}, 32'h0);
        checkOutput("reset_valid",  {31'h0, ifIdValid}, 32'h0);

        for (int k = 0; k < 8; k++) begin
            checkOutput("hit_addr", {16'h0, imemAddr}, 32'(2 * k));
            expectFetch({4'h1, 12'(2 * k)}, 16'(2 * k + 2));
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        end

        for (int k = 0; k < 2; k++) begin
            checkOutput("stall_addr", {16'h0, imemAddr}, 32'h0010);
            expectFetch(16'h100E, 16'h0010);
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        end
        checkOutput("post_stall_addr", {16'h0, imemAddr}, 32'h0010);
        expectFetch(16'h1010, 16'h0012);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int k = 9; k < 16; k++) begin
            expectFetch({4'h1, 12'(2 * k)}, 16'(2 * k + 2));
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        end

        checkOutput("miss_start_addr", {16'h0, imemAddr}, 32'h0020);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("miss_hold_addr", {16'h0, imemAddr}, 32'h0020);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("miss_hold_addr2", {16'h0, imemAddr}, 32'h0020);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("redirect_addr", {16'h0, imemAddr}, 32'h0100);
        checkOutput("miss_bubble", {ifIdInst, ifIdPcPlus2}, {31'h0, ifIdValid});

        expectFetch(16'h1100, 16'h0102);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0030, 1'b1);
        checkOutput("prio_valid", {31'h0, ifIdValid}, 32'h0);
        checkOutput("prio_addr", {16'h0, imemAddr}, 32'h0030);

        hltAddr = 16'h0030;
        expectFetch(16'hF000, 16'h0032);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("hlt_halted", {31'h0, halted}, 32'h1);
        checkOutput("hlt_req", {31'h0, imemReq}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput("hlt_hold_addr", {16'h0, imemAddr}, 32'h0030);
            checkOutput("hlt_hold_halted", {31'h0, halted}, 32'h1);
        end
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
        checkOutput("unhalt_halted", {31'h0, halted}, 32'h0);
        checkOutput("unhalt_addr", {16'h0, imemAddr}, 32'h0040);
        checkOutput("unhalt_req", {31'h0, imemReq}, 32'h1);

        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1);
        checkOutput("wrap_start", {16'h0, imemAddr}, 32'hFFFE);
        expectFetch(16'h1FFE, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_addr", {16'h0, imemAddr}, 32'h0000);

        expectFetch(16'h1000, 16'h0002);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        expectFetch(16'h1002, 16'h0004);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
        checkOutput("miss_rst_pre", {16'h0, imemAddr}, 32'h0004);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        checkOutput("mid_rst_addr", {16'h0, imemAddr}, 32'h0000);
        checkOutput("mid_rst_valid", {31'h0, ifIdValid}, 32'h0);
        checkOutput("mid_rst_halted", {31'h0, halted}, 32'h0);
        expectFetch(16'h1000, 16'h0002);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("no_pend_addr", {16'h0, imemAddr}, 32'h0002);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
